alu_exec: RTL
=============

Name: alu_exec

Overview:
Execute-stage ALU driven by the 5-bit alucontrol code from the ALU decoder. Logic, immediate-logic, LUI, add/sub/compare and HI/LO moves complete in the issue cycle. MULT/MULTU write HI/LO in one cycle. DIV/DIVU run on an iterative radix-2 divider that stalls the pipeline until the result is ready. The block owns the architectural HI/LO registers.

Parameters:
DIV_CYCLES, 32, number of restoring-division iterations (one quotient bit per cycle)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
valid_i  in  1  instruction in EX is valid
flush_i  in  1  abort any in-flight divide; suppress HI/LO writes this cycle
alucontrol  in  5  operation code (encodings below)
a_i  in  32  operand A (rs)
b_i  in  32  operand B (rt, or immediate already extended by the datapath)
result_o  out  32  combinational result for non-HI/LO-writing ops
overflow_o  out  1  signed overflow on ALU_ADD/ALU_SUB
stall_o  out  1  hold EX and all earlier stages
hi_o  out  32  current HI register
lo_o  out  32  current LO register

Behaviour:
- Encodings: AND 00000, OR 00001, XOR 00010, NOR 00011, ANDI 00100, XORI 00101, LUI 00110, ORI 00111, ADD 01000, SUB 01001, SLT 01010, SLTU 01011, MULT 01100, MULTU 01101, DIV 01110, DIVU 01111, MFHI 10000, MFLO 10001, MTHI 10010, MTLO 10011, DONOTHING 11111. Any other code is treated as DONOTHING.
- result_o:
  - ANDI/ORI/XORI use b_i as given.
  - LUI = {b_i[15:0],16'h0}.
  - SLT/SLTU = zero-extended 1-bit compare.
  - MFHI/MFLO = HI/LO.
  - DONOTHING, mult/div and MT* ops = 0.
- overflow_o = 1 only for ADD/SUB with signed overflow; 0 otherwise.
- Reset: state IDLE, HI=LO=0, stall_o=0. While rst is asserted, result_o and overflow_o read 0.
- HI/LO writes:
  - Occur at a clock edge only when valid_i=1, flush_i=0 and stall_o=0.
  - MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product.
  - MTHI: HI=a_i. MTLO: LO=a_i.
  - MF* in the cycle after a write reads the new value; there is no same-cycle bypass.
- Divide FSM, states IDLE, BUSY, DONE:
  - IDLE: valid_i & ~flush_i & (DIV|DIVU) → latch |a|,|b| and signs, count=0, go to BUSY. stall_o=1 combinationally in this issue cycle.
  - BUSY: one iteration per cycle, stall_o=1. When count reaches DIV_CYCLES-1, go to DONE.
  - DONE: stall_o=0. Quotient→LO and remainder→HI at the closing edge, then return to IDLE unconditionally. A DIV still present on alucontrol in DONE never restarts.
  - Total stall = DIV_CYCLES+1 = 33 cycles. Results are visible on hi_o/lo_o the cycle after DONE.
  - Signed results: quotient negative iff signs differ; remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero: LO=0xFFFFFFFF, HI=a_i (dividend). Full latency unless the optional feature is enabled.
- flush_i: from any state, next state is IDLE. HI/LO are unchanged. stall_o is forced to 0 in the flush cycle.
- rst mid-divide: same as reset, so HI=LO=0 and state IDLE.
- Operands are latched at issue. a_i/b_i changes during BUSY are ignored.

Optional Feature:
ALU_DIV_ZERO_FAST_EN
- Defined: a DIV/DIVU with b_i==0 goes IDLE→DONE directly. stall_o is high for the issue cycle only (1 cycle). Results are the same as in the non-fast case.
- Undefined: divide by zero takes the normal 33-cycle stall.

Test Plan:
1. Logic/immediate ops: AND/OR/XOR/NOR with a=0xF0F0_00FF, b=0x0FF0_0F0F → 0x00F0_000F, 0xFFF0_0FFF, 0xFF00_0FF0, 0x000F_F000. LUI b=0x1234 → 0x1234_0000.
2. ADD 0x7FFFFFFF+1 → result 0x80000000, overflow_o=1. SUB 5-7 → 0xFFFFFFFE, overflow_o=0. SLT -1<1 → 1. SLTU same operands → 0.
3. MULT a=-3, b=5 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU 0xFFFFFFFF*2 → HI=1, LO=0xFFFFFFFE. MTHI 0xABCD then MFHI → 0xABCD.
4. DIV a=-7, b=2 → stall_o high for exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
5. DIV issued with HI=LO=0x11, flush_i asserted on the 10th stall cycle → stall_o low that cycle, FSM in IDLE, HI/LO still 0x11. Repeat with rst instead → HI=LO=0.
6. DIVU 9/0 → LO=0xFFFFFFFF, HI=9. Stall is 33 cycles without ALU_DIV_ZERO_FAST_EN and 1 cycle with it.

Source files
------------

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute-stage ALU with HI/LO registers and iterative radix-2 divider
//
// Purpose: single-cycle logic/arith/compare/move ops, one-cycle MULT/MULTU into
// HI/LO, and a restoring DIV/DIVU that stalls the pipeline until the result lands.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   valid_i           instruction in EX is valid
//   flush_i           abort any in-flight divide, block HI/LO writes this cycle
//   alucontrol[4:0]   operation code
//   a_i, b_i [31:0]   operands (b_i may be an already-extended immediate)
//   result_o [31:0]   combinational result
//   overflow_o        signed overflow on ADD/SUB
//   stall_o           hold EX and earlier stages
//   hi_o, lo_o        architectural HI/LO registers
//
// Optional feature macro: ALU_DIV_ZERO_FAST_EN (divide by zero skips the iterations)

module alu_exec #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [4:0]  alucontrol,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        overflow_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_XOR   = 5'b00010;
  localparam logic [4:0] OP_NOR   = 5'b00011;
  localparam logic [4:0] OP_ANDI  = 5'b00100;
  localparam logic [4:0] OP_XORI  = 5'b00101;
  localparam logic [4:0] OP_LUI   = 5'b00110;
  localparam logic [4:0] OP_ORI   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_SUB   = 5'b01001;
  localparam logic [4:0] OP_SLT   = 5'b01010;
  localparam logic [4:0] OP_SLTU  = 5'b01011;
  localparam logic [4:0] OP_MULT  = 5'b01100;
  localparam logic [4:0] OP_MULTU = 5'b01101;
  localparam logic [4:0] OP_DIV   = 5'b01110;
  localparam logic [4:0] OP_DIVU  = 5'b01111;
  localparam logic [4:0] OP_MFHI  = 5'b10000;
  localparam logic [4:0] OP_MFLO  = 5'b10001;
  localparam logic [4:0] OP_MTHI  = 5'b10010;
  localparam logic [4:0] OP_MTLO  = 5'b10011;

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rem_q, rem_d;   // partial remainder
  logic [31:0]   quo_q, quo_d;   // dividend shifts out the top, quotient bits shift in
  logic [31:0]   dvs_q, dvs_d;   // divisor magnitude
  logic [31:0]   dvd_q, dvd_d;   // raw dividend, returned as HI on divide by zero
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic          dz_q, dz_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic        is_div;
  logic        is_signed_div;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh, rem_diff;
  logic        q_bit;
  logic [31:0] quo_fin, rem_fin;
  logic [63:0] prod_s, prod_u;
  logic [31:0] sum, diff;
  logic        fast_dz;

  assign is_div        = (alucontrol == OP_DIV) || (alucontrol == OP_DIVU);
  assign is_signed_div = (alucontrol == OP_DIV);
  assign a_neg         = is_signed_div & a_i[31];
  assign b_neg         = is_signed_div & b_i[31];
  assign a_abs         = a_neg ? (~a_i + 32'd1) : a_i;
  assign b_abs         = b_neg ? (~b_i + 32'd1) : b_i;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The borrow out of bit 32 doubles as "does not fit" because rem < divisor.
  assign rem_sh   = {rem_q, quo_q[31]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};
  assign q_bit    = ~rem_diff[32];

  assign quo_fin = negq_q ? (~quo_q + 32'd1) : quo_q;
  assign rem_fin = negr_q ? (~rem_q + 32'd1) : rem_q;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};
  assign sum    = a_i + b_i;
  assign diff   = a_i - b_i;

`ifdef ALU_DIV_ZERO_FAST_EN
  assign fast_dz = (b_i == 32'd0);
`else
  assign fast_dz = 1'b0;
`endif

  // Stall is combinational so the issuing DIV is held in the same cycle.
  assign stall_o = ~rst & ~flush_i &
                   (((state_q == S_IDLE) & valid_i & is_div) | (state_q == S_BUSY));

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  always_comb begin
    result_o   = 32'd0;
    overflow_o = 1'b0;
    if (!rst) begin
      case (alucontrol)
        OP_AND, OP_ANDI: result_o = a_i & b_i;
        OP_OR,  OP_ORI:  result_o = a_i | b_i;
        OP_XOR, OP_XORI: result_o = a_i ^ b_i;
        OP_NOR:          result_o = ~(a_i | b_i);
        OP_LUI:          result_o = {b_i[15:0], 16'h0000};
        OP_ADD: begin
          result_o   = sum;
          overflow_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
        end
        OP_SUB: begin
          result_o   = diff;
          overflow_o = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
        end
        OP_SLT:  result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
        OP_SLTU: result_o = {31'd0, (a_i < b_i)};
        OP_MFHI: result_o = hi_q;
        OP_MFLO: result_o = lo_q;
        default: result_o = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i && is_div) begin
            state_d = fast_dz ? S_DONE : S_BUSY;
            cnt_d   = '0;
            rem_d   = 32'd0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            dvd_d   = a_i;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            dz_d    = (b_i == 32'd0);
          end else if (valid_i) begin
            case (alucontrol)
              OP_MULT:  {hi_d, lo_d} = prod_s;
              OP_MULTU: {hi_d, lo_d} = prod_u;
              OP_MTHI:  hi_d = a_i;
              OP_MTLO:  lo_d = a_i;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          rem_d = q_bit ? rem_diff[31:0] : rem_sh[31:0];
          quo_d = {quo_q[30:0], q_bit};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DIV_CYCLES - 1)) state_d = S_DONE;
        end
        S_DONE: begin
          // The DIV leaves EX at this edge, so it never re-issues.
          state_d = S_IDLE;
          hi_d    = dz_q ? dvd_q : rem_fin;
          lo_d    = dz_q ? 32'hFFFF_FFFF : quo_fin;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      dvd_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
